// File: rtl/neuron_seq_pkg.sv
// rtl/neuron_seq_pkg.sv - shared types, widths and frame-length helper for the neuron pool sequencer
package neuron_seq_pkg;

  localparam int SPKID_W     = 16;
  localparam int MARKER_BIT  = 15;
  localparam int FRAME_CNT_W = 15;
  localparam int CYC_W       = 20;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    WAIT
  } seq_state_e;

  // Requested frame length 2*half+2, widened so the largest half_cnt cannot wrap.
  function automatic logic [CYC_W-1:0] frame_req(input logic [17:0] half);
    return {1'b0, half, 1'b0} + CYC_W'(2);
  endfunction

endpackage

// File: rtl/spkid_fifo.sv
// rtl/spkid_fifo.sv - single-clock first-word-fall-through FIFO for spike id words
module spkid_fifo #(
  parameter int WIDTH   = 16,
  parameter int FIFO_AW = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   push_data_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               empty_o,
  output logic               full_o,
  output logic [FIFO_AW:0]   count_o
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the head slot in the same edge, so a full FIFO still accepts the push.
  assign do_push = push_i & (~full_o | do_pop);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/neuron_pool_sequencer.sv
// rtl/neuron_pool_sequencer.sv - issues neuron slots per frame, aligns spikes and buffers tagged spike words
// Optional SPKID_FRAME_MARKER_EN: push a {1, frame number} marker word at every frame_done.
module neuron_pool_sequencer
  import neuron_seq_pkg::*;
#(
  parameter int NN       = 8,
  parameter int PIPE_LAT = 4,
  parameter int FIFO_AW  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [17:0]            half_cnt,
  output logic [NN-1:0]          neuron_idx,
  output logic                   slot_valid,
  input  logic                   spike_in,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  input  logic                   rd_en,
  output logic [SPKID_W-1:0]     rd_data,
  output logic                   fifo_empty,
  output logic [FIFO_AW:0]       fifo_count,
  output logic                   overflow,
  output logic                   overrun
);

  localparam logic [CYC_W-1:0] N_SLOTS = CYC_W'(2 ** NN);
  localparam logic [CYC_W-1:0] MIN_LEN = CYC_W'(2 ** NN + PIPE_LAT);

  seq_state_e             state_q, state_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d;
  logic [CYC_W-1:0]       len_q, len_d;
  logic [CYC_W-1:0]       len_req;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   overrun_q, overrun_d;
  logic                   overflow_q;
  logic                   frame_start, last_cyc;

  assign len_req    = frame_req(half_cnt);
  assign last_cyc   = (cyc_q == len_q - CYC_W'(1));
  assign slot_valid = (state_q == RUN);
  assign neuron_idx = (state_q == RUN) ? cyc_q[NN-1:0] : '0;
  assign frame_cnt  = frame_cnt_q;
  assign overrun    = overrun_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    len_d       = len_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    frame_done  = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      IDLE:  frame_start = enable;
      RUN: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q == N_SLOTS - CYC_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (last_cyc) frame_done = 1'b1;
        else if (cyc_q == MIN_LEN - CYC_W'(1)) state_d = WAIT;
      end
      WAIT: begin
        cyc_d      = cyc_q + CYC_W'(1);
        frame_done = last_cyc;
      end
      default: state_d = IDLE;
    endcase
    // enable is only consulted at frame boundaries, so a mid-frame drop finishes the frame.
    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      state_d     = IDLE;
      frame_start = enable;
    end
    if (frame_start) begin
      state_d = RUN;
      cyc_d   = '0;
      len_d   = (len_req < MIN_LEN) ? MIN_LEN : len_req;
      if (len_req < MIN_LEN) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      len_q       <= MIN_LEN;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      len_q       <= len_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  // Slot tag delay line, matched to the datapath latency.
  logic [PIPE_LAT-1:0] dly_v_q;
  logic [NN-1:0]       dly_idx_q [PIPE_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_v_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) dly_idx_q[i] <= '0;
    end else begin
      dly_v_q[0]   <= slot_valid;
      dly_idx_q[0] <= neuron_idx;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dly_v_q[i]   <= dly_v_q[i-1];
        dly_idx_q[i] <= dly_idx_q[i-1];
      end
    end
  end

  logic               spike_push;
  logic [SPKID_W-1:0] spike_word;
  logic               push_req;
  logic [SPKID_W-1:0] push_data;
  logic               fifo_full, fifo_pop;

  assign spike_push = spike_in & dly_v_q[PIPE_LAT-1];
  assign spike_word = {1'b0, frame_cnt_q[FRAME_CNT_W-1-NN:0], dly_idx_q[PIPE_LAT-1]};
  assign fifo_pop   = rd_en & ~fifo_empty;

`ifdef SPKID_FRAME_MARKER_EN
  logic               mk_pend_q, mk_pend_d;
  logic [SPKID_W-1:0] mk_word_q, mk_word_d, mk_now;

  // A marker colliding with a spike is deferred one cycle so the spike lands first.
  always_comb begin
    mk_now                        = '0;
    mk_now[MARKER_BIT]            = 1'b1;
    mk_now[FRAME_CNT_W-1:0]       = frame_cnt_q + FRAME_CNT_W'(1);
    push_req  = 1'b0;
    push_data = spike_word;
    mk_pend_d = mk_pend_q;
    mk_word_d = mk_word_q;
    if (spike_push) begin
      push_req = 1'b1;
    end else if (mk_pend_q) begin
      push_req  = 1'b1;
      push_data = mk_word_q;
      mk_pend_d = 1'b0;
    end else if (frame_done) begin
      push_req  = 1'b1;
      push_data = mk_now;
    end
    if (frame_done && (spike_push || mk_pend_q)) begin
      mk_pend_d = 1'b1;
      mk_word_d = mk_now;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mk_pend_q <= 1'b0;
      mk_word_q <= '0;
    end else begin
      mk_pend_q <= mk_pend_d;
      mk_word_q <= mk_word_d;
    end
  end
`else
  assign push_req  = spike_push;
  assign push_data = spike_word;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else if (push_req && fifo_full && !fifo_pop) overflow_q <= 1'b1;
  end

  spkid_fifo #(
    .WIDTH   (SPKID_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push_req),
    .push_data_i (push_data),
    .pop_i       (rd_en),
    .rd_data_o   (rd_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

endmodule
